// File: rtl/q_episode_sequencer.sv
// q_episode_sequencer: walks Q-learning maze episodes over one shared Q-table RAM and an
// external req/ack update unit. Optional exploration: define Q_SEQ_EXPLORE_EN.
module q_episode_sequencer #(
   parameter int                 NUM_EPISODES = 100,
   parameter int                 MAX_STEPS    = 64,
   parameter logic signed [31:0] REWARD_GOAL  = 32'sd100,
   parameter logic signed [31:0] REWARD_STEP  = -32'sd1,
   parameter logic signed [31:0] REWARD_BLOCK = -32'sd10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [5:0]         start_state,
   input  logic [5:0]         target_state,
   input  logic [36:0]        blocked_mask,
   output logic [7:0]         q_addr,
   output logic               q_rd_en,
   input  logic signed [31:0] q_rd_data,
   output logic               q_wr_en,
   output logic [31:0]        q_wr_data,
   output logic               upd_req,
   output logic [31:0]        upd_q_old,
   output logic [31:0]        upd_max_next,
   output logic [31:0]        upd_reward,
   input  logic               upd_ack,
   input  logic [31:0]        upd_q_new,
   output logic               busy,
   output logic               done,
   output logic [7:0]         episode_cnt,
   output logic [5:0]         cur_state
);

   localparam logic [7:0] NUM_EP_C    = 8'(NUM_EPISODES);
   localparam logic [7:0] MAX_STEPS_C = 8'(MAX_STEPS);

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_EP_START = 4'd1,
      ST_RD_CUR   = 4'd2,
      ST_DECIDE   = 4'd3,
      ST_RD_NXT   = 4'd4,
      ST_UPD      = 4'd5,
      ST_WRITE    = 4'd6,
      ST_EP_END   = 4'd7,
      ST_DONE     = 4'd8
   } state_t;

   state_t             state_r;
   logic [5:0]         start_state_r;
   logic [5:0]         target_r;
   logic [36:0]        blocked_r;
   logic [7:0]         step_cnt_r;
   logic [2:0]         sub_r;
   logic signed [31:0] q_r [0:3];
   logic [1:0]         act_r;
   logic [5:0]         nxt_r;
`ifdef Q_SEQ_EXPLORE_EN
   logic [15:0]        lfsr_r;
`endif

   logic [1:0]         sub_idx_s;
   logic [1:0]         best_act_s;
   logic [1:0]         act_s;
   logic [5:0]         col_s;
   logic [5:0]         dest_s;
   logic               legal_s;
   logic [5:0]         nxt_s;
   logic signed [31:0] reward_s;

   // Ties resolve to the lower index: pairwise tournament, left side wins equality.
   function automatic logic [1:0] argmax4(input logic signed [31:0] q0, input logic signed [31:0] q1,
                                          input logic signed [31:0] q2, input logic signed [31:0] q3);
      logic signed [31:0] m01;
      logic signed [31:0] m23;
      logic [1:0]         i01;
      logic [1:0]         i23;
      m01 = (q1 > q0) ? q1 : q0;
      i01 = (q1 > q0) ? 2'd1 : 2'd0;
      m23 = (q3 > q2) ? q3 : q2;
      i23 = (q3 > q2) ? 2'd3 : 2'd2;
      return (m23 > m01) ? i23 : i01;
   endfunction

   function automatic logic signed [31:0] max4(input logic signed [31:0] q0, input logic signed [31:0] q1,
                                               input logic signed [31:0] q2, input logic signed [31:0] q3);
      logic signed [31:0] m01;
      logic signed [31:0] m23;
      m01 = (q1 > q0) ? q1 : q0;
      m23 = (q3 > q2) ? q3 : q2;
      return (m23 > m01) ? m23 : m01;
   endfunction

   assign sub_idx_s = sub_r[1:0] - 2'd1;

   // Action choice, destination cell and step reward for the current state.
   always_comb begin
      best_act_s = argmax4(q_r[0], q_r[1], q_r[2], q_r[3]);
`ifdef Q_SEQ_EXPLORE_EN
      if (lfsr_r[3:0] == 4'd0) begin
         act_s = lfsr_r[5:4];
      end else begin
         act_s = best_act_s;
      end
`else
      act_s = best_act_s;
`endif
      col_s   = cur_state % 6'd6;
      legal_s = 1'b0;
      dest_s  = cur_state;
      case (act_s)
         2'd0: begin legal_s = (cur_state >= 6'd6);  dest_s = cur_state - 6'd6; end
         2'd1: begin legal_s = (cur_state <= 6'd29); dest_s = cur_state + 6'd6; end
         2'd2: begin legal_s = (col_s != 6'd0);      dest_s = cur_state - 6'd1; end
         2'd3: begin legal_s = (col_s != 6'd5);      dest_s = cur_state + 6'd1; end
         default: begin legal_s = 1'b0;              dest_s = cur_state;        end
      endcase
      if (legal_s && !blocked_r[dest_s]) begin
         nxt_s    = dest_s;
         reward_s = (dest_s == target_r) ? REWARD_GOAL : REWARD_STEP;
      end else begin
         nxt_s    = cur_state;
         reward_s = REWARD_BLOCK;
      end
   end

   // Episode/step sequencer with all outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= ST_IDLE;
         start_state_r <= 6'd0;
         target_r      <= 6'd0;
         blocked_r     <= 37'd0;
         step_cnt_r    <= 8'd0;
         sub_r         <= 3'd0;
         for (int i = 0; i < 4; i++) q_r[i] <= 32'sd0;
         act_r         <= 2'd0;
         nxt_r         <= 6'd0;
`ifdef Q_SEQ_EXPLORE_EN
         lfsr_r        <= 16'hACE1;
`endif
         q_addr        <= 8'd0;
         q_rd_en       <= 1'b0;
         q_wr_en       <= 1'b0;
         q_wr_data     <= 32'd0;
         upd_req       <= 1'b0;
         upd_q_old     <= 32'd0;
         upd_max_next  <= 32'd0;
         upd_reward    <= 32'd0;
         busy          <= 1'b0;
         done          <= 1'b0;
         episode_cnt   <= 8'd0;
         cur_state     <= 6'd0;
      end else begin
         q_wr_en <= 1'b0;
         done    <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  start_state_r <= start_state;
                  target_r      <= target_state;
                  blocked_r     <= blocked_mask;
                  cur_state     <= start_state;
                  episode_cnt   <= 8'd0;
                  busy          <= 1'b1;
`ifdef Q_SEQ_EXPLORE_EN
                  lfsr_r        <= 16'hACE1;
`endif
                  state_r       <= ST_EP_START;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_EP_START: begin
               step_cnt_r <= 8'd0;
               if (cur_state == target_r) begin
                  state_r <= ST_EP_END;
               end else begin
                  sub_r   <= 3'd0;
                  q_rd_en <= 1'b1;
                  q_addr  <= {cur_state, 2'd0};
                  state_r <= ST_RD_CUR;
               end
            end
            // Reads issue on sub 0..3; data for read k lands on sub k+1.
            ST_RD_CUR, ST_RD_NXT: begin
               if (sub_r != 3'd0) q_r[sub_idx_s] <= q_rd_data;
               if (sub_r == 3'd4) begin
                  sub_r <= 3'd0;
                  if (state_r == ST_RD_NXT) begin
                     upd_max_next <= max4(q_r[0], q_r[1], q_r[2], q_rd_data);
                     upd_req      <= 1'b1;
                     state_r      <= ST_UPD;
                  end else begin
                     state_r <= ST_DECIDE;
                  end
               end else begin
                  sub_r   <= sub_r + 3'd1;
                  q_rd_en <= (sub_r != 3'd3);
                  q_addr  <= {((state_r == ST_RD_NXT) ? nxt_r : cur_state), sub_r[1:0] + 2'd1};
               end
            end
            ST_DECIDE: begin
               act_r      <= act_s;
               nxt_r      <= nxt_s;
               upd_reward <= reward_s;
               upd_q_old  <= q_r[act_s];
`ifdef Q_SEQ_EXPLORE_EN
               lfsr_r     <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
`endif
               if (nxt_s == target_r) begin
                  upd_max_next <= 32'd0;
                  upd_req      <= 1'b1;
                  state_r      <= ST_UPD;
               end else begin
                  sub_r   <= 3'd0;
                  q_rd_en <= 1'b1;
                  q_addr  <= {nxt_s, 2'd0};
                  state_r <= ST_RD_NXT;
               end
            end
            ST_UPD: begin
               if (upd_ack) begin
                  upd_req   <= 1'b0;
                  q_wr_data <= upd_q_new;
                  q_wr_en   <= 1'b1;
                  q_addr    <= {cur_state, act_r};
                  state_r   <= ST_WRITE;
               end else begin
                  state_r <= ST_UPD;
               end
            end
            ST_WRITE: begin
               cur_state  <= nxt_r;
               step_cnt_r <= step_cnt_r + 8'd1;
               if ((nxt_r == target_r) || (step_cnt_r + 8'd1 == MAX_STEPS_C)) begin
                  state_r <= ST_EP_END;
               end else begin
                  sub_r   <= 3'd0;
                  q_rd_en <= 1'b1;
                  q_addr  <= {nxt_r, 2'd0};
                  state_r <= ST_RD_CUR;
               end
            end
            ST_EP_END: begin
               episode_cnt <= episode_cnt + 8'd1;
               cur_state   <= start_state_r;
               if (episode_cnt + 8'd1 == NUM_EP_C) begin
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state_r <= ST_DONE;
               end else begin
                  state_r <= ST_EP_START;
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_q_episode_sequencer.sv
// Table-driven bench for q_episode_sequencer with a behavioural Q-RAM and update unit
// (q_new = q_old + reward + max_next).
`timescale 1ns/1ps
module tb_q_episode_sequencer;

   localparam int SENT = -12345;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic [5:0]         start_state;
   logic [5:0]         target_state;
   logic [36:0]        blocked_mask;
   logic [7:0]         q_addr;
   logic               q_rd_en;
   logic signed [31:0] q_rd_data = 32'sd0;
   logic               q_wr_en;
   logic [31:0]        q_wr_data;
   logic               upd_req;
   logic [31:0]        upd_q_old;
   logic [31:0]        upd_max_next;
   logic [31:0]        upd_reward;
   logic               upd_ack;
   logic [31:0]        upd_q_new;
   logic               busy;
   logic               done;
   logic [7:0]         episode_cnt;
   logic [5:0]         cur_state;

   int tests = 0;
   int fails = 0;
   logic clr_mon = 1'b0;
   int pre_addr = 0;
   int pre_val = 0;
   int ack_delay = 0;
   int wait_cnt = 0;

   q_episode_sequencer #(.NUM_EPISODES(2), .MAX_STEPS(3)) dut (
      .clk(clk), .rst(rst), .start(start), .start_state(start_state),
      .target_state(target_state), .blocked_mask(blocked_mask), .q_addr(q_addr),
      .q_rd_en(q_rd_en), .q_rd_data(q_rd_data), .q_wr_en(q_wr_en), .q_wr_data(q_wr_data),
      .upd_req(upd_req), .upd_q_old(upd_q_old), .upd_max_next(upd_max_next),
      .upd_reward(upd_reward), .upd_ack(upd_ack), .upd_q_new(upd_q_new), .busy(busy),
      .done(done), .episode_cnt(episode_cnt), .cur_state(cur_state)
   );

   always #5 clk = ~clk;

   // Q-table RAM model, one-cycle read latency
   logic [31:0] mem [0:255];
   always @(posedge clk) begin
      if (clr_mon) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
         mem[pre_addr] <= pre_val;
      end else begin
         if (q_rd_en) q_rd_data <= mem[q_addr];
         if (q_wr_en) mem[q_addr] <= q_wr_data;
      end
   end

   // Update unit: acks after ack_delay extra cycles
   always @(posedge clk) begin
      if (!upd_req) wait_cnt <= 0;
      else          wait_cnt <= wait_cnt + 1;
   end
   assign upd_ack   = upd_req && (wait_cnt == ack_delay);
   assign upd_q_new = upd_q_old + upd_reward + upd_max_next;

   // Monitor sampled on the falling edge
   int wr_cnt, a1, d1, a2, c1, gap, rew1, max1, done_cnt, ovl, unst, cyc;
   logic upd_seen, in_upd;
   logic [95:0] snap;
   always @(negedge clk) begin
      if (clr_mon) begin
         wr_cnt <= 0; a1 <= -1; d1 <= SENT; a2 <= -1; c1 <= 0; gap <= -1;
         rew1 <= SENT; max1 <= SENT; upd_seen <= 1'b0; done_cnt <= 0;
         ovl <= 0; unst <= 0; in_upd <= 1'b0; cyc <= 0; snap <= 96'd0;
      end else begin
         cyc <= cyc + 1;
         if (q_wr_en) begin
            wr_cnt <= wr_cnt + 1;
            if (wr_cnt == 0) begin a1 <= int'(q_addr); d1 <= int'($signed(q_wr_data)); c1 <= cyc; end
            if (wr_cnt == 1) begin a2 <= int'(q_addr); gap <= cyc - c1; end
         end
         if (q_rd_en && q_wr_en) ovl <= ovl + 1;
         if (done) done_cnt <= done_cnt + 1;
         in_upd <= upd_req;
         if (upd_req && !in_upd) begin
            snap <= {upd_q_old, upd_max_next, upd_reward};
            if (!upd_seen) begin
               rew1 <= int'($signed(upd_reward));
               max1 <= int'($signed(upd_max_next));
               upd_seen <= 1'b1;
            end
         end
         if (upd_req && in_upd && ({upd_q_old, upd_max_next, upd_reward} != snap)) unst <= unst + 1;
      end
   end

   typedef struct {
      logic [5:0]  st;
      logic [5:0]  tg;
      logic [36:0] blk;
      int pre_addr, pre_val, delay;
      int exp_writes, exp_a1, exp_d1, exp_a2, exp_gap, exp_rew, exp_max;
   } vec_t;
   vec_t vecs [6];

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic prep(input vec_t v);
      start_state = v.st; target_state = v.tg; blocked_mask = v.blk;
      pre_addr = v.pre_addr; pre_val = v.pre_val; ack_delay = v.delay;
      clr_mon = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      clr_mon = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (done_cnt == 0 && n < 3000) begin @(negedge clk); n++; end
      if (done_cnt == 0) begin
         tests++; fails++;
         $display("FAIL %s_timeout: got no done, expected done within 3000 cycles", name);
      end
      repeat (5) @(negedge clk);
   endtask

   initial begin
      //          st     tg     blk                                  pa  pv dly wr a1  d1  a2 gap rew  max
      vecs[0] = '{6'd0,  6'd1,  37'd0,                                0,  0, 0, 5, 0, -10, 1, 13, -10, 0};
      vecs[1] = '{6'd14, 6'd15, 37'd0,                               59,  5, 0, 2, 59, 105, 59, 10, 100, 0};
      vecs[2] = '{6'd7,  6'd7,  37'd0,                                0,  0, 0, 0, -1, SENT, -1, -1, SENT, SENT};
      vecs[3] = '{6'd8,  6'd35, (37'd1 << 9),                        35, 50, 0, 6, 35, 90, 35, 13, -10, 50};
      vecs[4] = '{6'd14, 6'd15, 37'd0,                               59,  5, 7, 2, 59, 105, 59, 17, 100, 0};
      vecs[5] = '{6'd0,  6'd35, ((37'd1 << 29) | (37'd1 << 34)),      0,  0, 0, 6, 0, -10, 1, 13, -10, 0};

      rst = 1'b1; start = 1'b0; start_state = 6'd0; target_state = 6'd0; blocked_mask = 37'd0;
      repeat (3) @(posedge clk); #1;
      chk("reset_ctrl", {29'd0, busy, done, q_rd_en, q_wr_en, upd_req}, 0);
      chk("reset_cnt", {episode_cnt, cur_state, q_addr}, 0);
      chk("reset_wdata", int'(q_wr_data), 0);
      chk("reset_upd", int'(upd_q_old | upd_max_next | upd_reward), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int k = 0; k < 6; k++) begin
         prep(vecs[k]);
         wait_done($sformatf("v%0d", k));
         chk($sformatf("v%0d_writes", k), wr_cnt, vecs[k].exp_writes);
         chk($sformatf("v%0d_addr1", k), a1, vecs[k].exp_a1);
         chk($sformatf("v%0d_data1", k), d1, vecs[k].exp_d1);
         chk($sformatf("v%0d_addr2", k), a2, vecs[k].exp_a2);
         chk($sformatf("v%0d_gap", k), gap, vecs[k].exp_gap);
         chk($sformatf("v%0d_reward", k), rew1, vecs[k].exp_rew);
         chk($sformatf("v%0d_maxnext", k), max1, vecs[k].exp_max);
         chk($sformatf("v%0d_episodes", k), int'(episode_cnt), 2);
         chk($sformatf("v%0d_done_cnt", k), done_cnt, 1);
         chk($sformatf("v%0d_busy_after", k), int'(busy), 0);
         chk($sformatf("v%0d_rdwr_overlap", k), ovl, 0);
         chk($sformatf("v%0d_upd_stable", k), unst, 0);
      end

      // Second start and config changes while busy must be ignored
      prep(vecs[5]);
      repeat (20) @(negedge clk);
      start_state = 6'd14; target_state = 6'd15; blocked_mask = 37'd0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done("busy_start");
      chk("busy_start_writes", wr_cnt, 6);
      chk("busy_start_done", done_cnt, 1);
      chk("busy_start_cur_state", int'(cur_state), 0);
      chk("busy_start_addr1", a1, 0);

      // Reset asserted while waiting for the update ack
      begin
         vec_t v;
         int n;
         v = vecs[1];
         v.delay = 50;
         prep(v);
         n = 0;
         while (!upd_req && n < 200) begin @(negedge clk); n++; end
         chk("rst_upd_reached", int'(upd_req), 1);
         repeat (3) @(negedge clk);
         #2 rst = 1'b1;
         #1;
         chk("rst_async_upd_req", int'(upd_req), 0);
         chk("rst_async_ctrl", {28'd0, busy, done, q_rd_en, q_wr_en}, 0);
         chk("rst_async_state", {episode_cnt, cur_state, q_addr}, 0);
         chk("rst_async_upd", int'(upd_q_old | upd_reward), 0);
         repeat (5) @(posedge clk);
         #1 rst = 1'b0;
         repeat (60) @(negedge clk);
         chk("rst_no_write", wr_cnt, 0);
         chk("rst_idle_busy", int'(busy), 0);
         chk("rst_no_done", done_cnt, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
